// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word type, fetch FSM states and PC increment
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, HALTED = 2'd2} fetch_state_t;
  localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel: priority next-PC/next-state mux and IF/ID strobe decode (FETCH_BUF_EN enables HOLD)
module fetch_pc_sel
  import cpu_types_pkg::*;
(
  input  fetch_state_t state,
  input  word_t        pc,
  input  logic         ihit,
  input  logic         stall,
  input  logic         id_jump,
  input  word_t        id_target,
  input  logic         ex_redirect,
  input  word_t        ex_target,
  input  logic         halt,
  output word_t        pc_d,
  output fetch_state_t state_d,
  output logic         ifw,
  output logic         ifrst
);
  // halt > ex_redirect > stall > id_jump > sequential; a buffered word counts as a hit
  always_comb begin
    pc_d = pc;
    state_d = RUN;
    ifw = 1'b0;
    ifrst = 1'b0;
    if (state == HALTED || halt) begin
      state_d = HALTED;
      ifrst = 1'b1;
    end else if (ex_redirect) begin
      pc_d = {ex_target[31:2], 2'b00};
      ifrst = 1'b1;
    end else if (stall) begin
`ifdef FETCH_BUF_EN
      state_d = (state == HOLD || ihit) ? HOLD : RUN;
`else
      state_d = RUN;
`endif
    end else if (id_jump) begin
      pc_d = {id_target[31:2], 2'b00};
      ifrst = 1'b1;
    end else if (ihit || state == HOLD) begin
      pc_d = pc + PC_STEP;
      ifw = 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS IF stage holding PC, state and optional one-entry fetch buffer (FETCH_BUF_EN)
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t iload,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  stall,
  input  logic  id_jump,
  input  word_t id_target,
  input  logic  ex_redirect,
  input  word_t ex_target,
  input  logic  halt,
  output word_t ifinstr,
  output word_t ifJALjump_addr,
  output logic  ifW,
  output logic  ifRST
);
  fetch_state_t state_q, state_d;
  word_t pc_q, pc_d;
  logic ifw, ifrst;
  word_t held_word;

  fetch_pc_sel u_sel (
    .state(state_q), .pc(pc_q), .ihit(ihit), .stall(stall),
    .id_jump(id_jump), .id_target(id_target),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .halt(halt),
    .pc_d(pc_d), .state_d(state_d), .ifw(ifw), .ifrst(ifrst)
  );

  // state and PC registers; reset restarts fetch at PC_INIT
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      pc_q <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_BUF_EN
  word_t buf_q, buf_d;

  // capture the hit word when a stall moves RUN into HOLD
  always_comb buf_d = (state_q == RUN && state_d == HOLD) ? iload : buf_q;

  // buffer contents are only meaningful in HOLD, so reset just clears them
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) buf_q <= '0;
    else buf_q <= buf_d;
  end

  assign held_word = buf_q;
`else
  assign held_word = '0;
`endif

  // reset overrides every strobe; word source follows the state
  always_comb begin
    imemaddr = pc_q;
    ifJALjump_addr = pc_q + PC_STEP;
    imemREN = !RST && state_q == RUN;
    ifW = !RST && ifw;
    ifRST = RST || ifrst;
    ifinstr = RST ? '0 : state_q == RUN ? iload : state_q == HOLD ? held_word : '0;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with directed vectors
module tb_fetch_unit;
  import cpu_types_pkg::*;

`ifdef FETCH_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  typedef struct {
    string nm;
    word_t a;
    logic  ren;
    logic  w;
    logic  r;
    word_t ins;
    word_t jal;
  } exp_t;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  ihit, stall, id_jump, ex_redirect, halt;
  word_t iload, id_target, ex_target;
  logic  imemREN, ifW, ifRST;
  word_t imemaddr, ifinstr, ifJALjump_addr;

  exp_t q[$];
  int passed = 0;
  int total = 0;

  localparam word_t W40 = 32'hA0A0_0040;
  localparam word_t JUNK = 32'h0BAD_0BAD;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .imemREN(imemREN),
    .imemaddr(imemaddr), .stall(stall), .id_jump(id_jump), .id_target(id_target),
    .ex_redirect(ex_redirect), .ex_target(ex_target), .halt(halt),
    .ifinstr(ifinstr), .ifJALjump_addr(ifJALjump_addr), .ifW(ifW), .ifRST(ifRST)
  );

  always #5 CLK = ~CLK;

  // monitor: outputs are settled mid-cycle, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({imemaddr, imemREN, ifW, ifRST, ifinstr, ifJALjump_addr} !== {e.a, e.ren, e.w, e.r, e.ins, e.jal})
          $display("FAIL %s: got addr=%h ren=%b w=%b rst=%b instr=%h jal=%h, expected addr=%h ren=%b w=%b rst=%b instr=%h jal=%h",
                   e.nm, imemaddr, imemREN, ifW, ifRST, ifinstr, ifJALjump_addr,
                   e.a, e.ren, e.w, e.r, e.ins, e.jal);
        else
          passed++;
      end
    end
  end

  task automatic set_in(input logic h, input word_t ld, input logic st, input logic ij,
                        input word_t it, input logic er, input word_t et, input logic hl);
    ihit = h; iload = ld; stall = st; id_jump = ij;
    id_target = it; ex_redirect = er; ex_target = et; halt = hl;
  endtask

  task automatic cyc(input string nm, input word_t a, input logic ren, input logic w,
                     input logic r, input word_t ins);
    exp_t e;
    e.nm = nm; e.a = a; e.ren = ren; e.w = w; e.r = r; e.ins = ins; e.jal = a + 32'd4;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    cyc("reset", 32'h0, 0, 0, 1, 32'h0);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h1000 + i, 0, 0, 0, 0, 0, 0);
      cyc("seq", 32'(i * 4), 1, 1, 0, 32'h1000 + i);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 32'hDEAD, 0, 0, 0, 0, 0, 0);
      cyc("miss", 32'h10, 1, 0, 0, 32'hDEAD);
    end
    set_in(1, 32'h2222, 0, 0, 0, 0, 0, 0);
    cyc("miss_hit", 32'h10, 1, 1, 0, 32'h2222);
    set_in(1, 32'h3333, 0, 1, 32'h23, 0, 0, 0);
    cyc("id_jump", 32'h14, 1, 0, 1, 32'h3333);
    set_in(1, 32'h4444, 0, 0, 0, 1, 32'h201, 0);
    cyc("ex_redirect", 32'h20, 1, 0, 1, 32'h4444);
    set_in(1, 32'h5555, 1, 1, 32'h400, 1, 32'h300, 0);
    cyc("redirect_over_jump", 32'h200, 1, 0, 1, 32'h5555);
    set_in(0, 32'h6666, 1, 1, 32'h400, 0, 0, 0);
    cyc("stall_ignores_jump", 32'h300, 1, 0, 0, 32'h6666);
    set_in(0, 32'h6666, 0, 0, 0, 0, 0, 0);
    cyc("pc_held", 32'h300, 1, 0, 0, 32'h6666);
    set_in(0, 32'h7777, 0, 1, 32'h40, 0, 0, 0);
    cyc("jump_40", 32'h300, 1, 0, 1, 32'h7777);
    set_in(1, W40, 1, 0, 0, 0, 0, 0);
    cyc("stall_first", 32'h40, 1, 0, 0, W40);
    set_in(1, BUF ? JUNK : W40, 1, 0, 0, 0, 0, 0);
    cyc("stall_second", 32'h40, !BUF, 0, 0, W40);
    set_in(1, BUF ? JUNK : W40, 0, 0, 0, 0, 0, 0);
    cyc("stall_release", 32'h40, !BUF, 1, 0, W40);
    set_in(1, 32'h8888, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    cyc("after_release", 32'h44, 1, 0, 1, 32'h8888);
    set_in(1, 32'h9999, 0, 0, 0, 0, 0, 0);
    cyc("wrap", 32'hFFFF_FFFC, 1, 1, 0, 32'h9999);
    set_in(1, 32'hAAAA, 0, 1, 32'h80, 0, 0, 0);
    cyc("wrapped_zero", 32'h0, 1, 0, 1, 32'hAAAA);
    set_in(1, 32'hBBBB, 0, 0, 0, 0, 0, 1);
    cyc("halt", 32'h80, 1, 0, 1, 32'hBBBB);
    for (int i = 0; i < 2; i++) begin
      set_in(1, 32'hCCCC, 0, 1, 32'h600, 1, 32'h500, 0);
      cyc("halted", 32'h80, 0, 0, 1, 32'h0);
    end
    RST = 1'b1;
    cyc("rst_pulse", 32'h0, 0, 0, 1, 32'h0);
    RST = 1'b0;
    set_in(1, 32'hDDDD, 0, 0, 0, 0, 0, 0);
    cyc("restart", 32'h0, 1, 1, 0, 32'hDDDD);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Holds the program counter and drives the instruction-cache request. Selects the next PC from sequential, decode-stage jump and execute-stage redirect sources. Produces the fetched word, PC+4 link address, and the IF/ID write and clear strobes.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  icache hit; iload is valid for imemaddr in the same cycle
- iload  in  32  instruction word from icache
- imemREN  out  1  icache read request
- imemaddr  out  32  fetch address (registered PC)
- stall  in  1  hazard unit: IF/ID must hold
- id_jump  in  1  J/JAL/JR resolved in decode
- id_target  in  32  decode-stage jump target
- ex_redirect  in  1  taken branch resolved in execute
- ex_target  in  32  execute-stage branch target
- halt  in  1  HALT retired; stop fetching permanently
- ifinstr  out  32  word presented to IF/ID
- ifJALjump_addr  out  32  PC+4 of the fetched word
- ifW  out  1  IF/ID write enable
- ifRST  out  1  IF/ID clear (effective only when ifW=0)

## Operation
- States: RUN, HOLD (only with FETCH_BUF_EN), HALTED. Reset state RUN.
- Event priority per cycle: halt > ex_redirect > stall > id_jump > sequential.
- halt: ifW=0, ifRST=1, next state HALTED. HALTED holds imemREN=0, ifW=0, ifRST=1 and a frozen PC until RST.
- ex_redirect in RUN or HOLD:
  - PC<=ex_target with bits [1:0] forced to 0.
  - ifW=0, ifRST=1; any concurrent ihit word is discarded.
  - Buffer invalidated; next state RUN.
- stall without redirect:
  - ifW=0, ifRST=0, PC held; id_jump is ignored because decode will re-present it.
- id_jump without stall:
  - PC<=id_target with [1:0]=0.
  - ifW=0, ifRST=1, discarding the wrong-path fetch.
- Sequential (RUN, no event):
  - ihit=1: ifW=1, PC<=PC+4.
  - ihit=0: ifW=0, ifRST=0, PC and imemaddr held.
- imemREN=1 in RUN; 0 in HOLD and HALTED.
- ifinstr=iload in RUN and =buffer in HOLD.
- ifJALjump_addr=PC+4 in all states. All PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- imemaddr is the PC register. imemREN, ifW, ifRST and ifinstr are combinational from state, PC, ihit and the control inputs; IF/ID captures them at the next edge.
- Hit latency 0: address at cycle n and ihit at n give ifW=1 at n, and the new address appears at n+1.
- A miss stretches the request: imemaddr and imemREN stay stable until ihit.
- While RST is high: PC=PC_INIT, state RUN, buffer invalid, imemREN=0, ifW=0, ifRST=1, ifinstr=0, ifJALjump_addr=PC_INIT+4.
- RST asserted mid-miss or in HOLD abandons the request. The first request after deassertion is to PC_INIT.

## Configuration
- FETCH_BUF_EN defined: one-entry fetch buffer.
  - ihit & stall (no halt/redirect) captures iload into the buffer and moves to HOLD.
  - In HOLD: imemREN=0 and ifW=~stall. When stall drops, ifW=1 with the buffered word, PC<=PC+4, and the next state is RUN.
- FETCH_BUF_EN undefined: no HOLD state and no buffer. During stall the request stays asserted at the held PC and the word is re-fetched after release.

## Structure
- cpu_types_pkg gains fetch_state_t (RUN, HOLD, HALTED) and the constant PC_STEP=4. Existing word_t is used for all 32-bit buses.
- One combinational sub-module, fetch_pc_sel, implements the priority next-PC mux and the ifW/ifRST decode. The state register, PC register and buffer live in fetch_unit.

## Test plan
- Reset release, ihit=1 every cycle, no events -> imemaddr 0,4,8,12 on successive cycles; ifW=1 each cycle; ifJALjump_addr 4,8,12,16.
- imemaddr=0x10 with ihit=0 for 3 cycles then 1 -> imemaddr 0x10 and imemREN=1 held for 4 cycles, ifW=0 for 3 cycles, ifW=1 on cycle 4, next imemaddr 0x14.
- ex_redirect=1 (0x200) coincident with ihit at 0x20 -> ifW=0, ifRST=1, next imemaddr 0x200.
- ex_redirect (0x300) and id_jump (0x400) together, with stall=1 -> next imemaddr 0x300, ifRST=1. Repeat with stall=1 and only id_jump -> PC held, ifRST=0.
- ihit with stall=1 for 2 cycles at 0x40:
  - Without the macro: imemaddr 0x40 and imemREN=1 throughout.
  - With FETCH_BUF_EN: imemREN=0 in HOLD, and on release ifW=1 with ifinstr equal to the captured word.
  - In both builds the next imemaddr is 0x44.
- halt=1 at PC 0x80 -> imemREN=0 and ifRST=1 from the next cycle, PC stays 0x80 despite ihit/redirect inputs. Pulsing RST gives imemaddr=PC_INIT.
